parity_serial_tx: RTL and testbench
===================================

PARITY_SERIAL_TX -- requirements
Module: parity_serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit; legal range 1..65535.
REQ-002 SHALL have parameter DATA_W, default 8, meaning payload width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_in  input  DATA_W  payload byte to transmit.
REQ-006 SHALL have port in_valid  input  1  data_in is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept a payload this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle-high.
REQ-009 SHALL have port busy  output  1  a frame is in progress.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 Frame SHALL be: start bit (0), DATA_W data bits LSB first, one parity bit, one stop bit (1); total DATA_W+3 bits.
REQ-012 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles; frame length SHALL be (DATA_W+3)*CLKS_PER_BIT cycles.
REQ-013 Parity bit SHALL be XOR of all captured data bits (even parity) unless REQ-024 applies.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 Transitions: IDLE->START on in_valid&&in_ready; START->DATA, DATA->PARITY after DATA_W bits, PARITY->STOP, STOP->IDLE, each at the end of its final bit period.
REQ-016 in_ready SHALL be 1 only in IDLE; busy SHALL equal !in_ready.
REQ-017 Payload and parity SHALL be captured in a register on the accept edge; data_in changes after accept SHALL NOT affect the frame.
REQ-018 tx SHALL drive start bit in the cycle after the accept edge.
REQ-019 tx_done SHALL pulse high for exactly one cycle, the first IDLE cycle after STOP.
REQ-020 in_valid during busy SHALL be ignored with no state change; a payload held valid SHALL be accepted in the tx_done cycle, giving back-to-back frames with one idle-high cycle between stop and next start.
REQ-021 Bit counter SHALL wrap to 0 at each bit-period boundary; data-bit index SHALL count 0..DATA_W-1 and clear on exit from DATA.

Reset
REQ-022 While rst is high: state=IDLE, tx=1, in_ready=1, busy=0, tx_done=0, counters and payload register=0, taking effect asynchronously.
REQ-023 Reset asserted mid-frame SHALL abort the frame with tx=1 immediately; no tx_done SHALL be issued for the aborted frame.

Configuration
REQ-024 With macro PARITY_TX_ODD_EN defined, parity bit SHALL be the inverse of the data XOR (odd parity); without it, even parity per REQ-013.

Structure
REQ-025 Package parity_pkg SHALL hold the FSM state typedef and the default DATA_W constant.
REQ-026 Sub-module parity_baud_tick SHALL implement the CLKS_PER_BIT counter, emitting a one-cycle bit-end tick; it SHALL restart on frame accept.

Verification
REQ-027 Default build, CLKS_PER_BIT=4, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1 each 4 cycles; tx_done at cycle 45 after accept.
REQ-028 Default build, send 0x01 -> parity bit 1; with PARITY_TX_ODD_EN, send 0xA5 -> parity bit 1.
REQ-029 in_valid held high with 0x3C then 0xC3 -> two frames, exactly one idle-high cycle between stop and second start, in_ready low throughout each frame.
REQ-030 Change data_in and pulse in_valid during DATA state -> frame bits unchanged, second payload not accepted.
REQ-031 Assert rst during DATA bit 3 -> tx=1 and busy=0 same cycle, no tx_done; next accepted frame is complete and correct.
REQ-032 CLKS_PER_BIT=1, send 0xFF -> 11-cycle frame, parity 0, tx_done in cycle 12.

Source files
------------

// File: rtl/parity_serial_tx_pkg.sv
// Shared types for the parity serial transmitter: FSM state encoding and default payload width.
package parity_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/parity_serial_tx_if.sv
// Payload handshake plus serial line/status bundle for parity_serial_tx.
interface parity_serial_tx_if
  import parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic [DATA_W-1:0] data_in;
  logic              in_valid;
  logic              in_ready;
  logic              tx;
  logic              busy;
  logic              tx_done;

  modport master (
    output data_in, in_valid,
    input  in_ready, tx, busy, tx_done
  );

  modport slave (
    input  data_in, in_valid,
    output in_ready, tx, busy, tx_done
  );

endinterface

// File: rtl/parity_serial_tx_baud_tick.sv
// Bit-period counter: tick_o is high in the last cycle of each CLKS_PER_BIT-long bit.
// Counter sits at 0 while not running and restarts from 0 on frame accept.
module parity_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int              CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !run_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parity_serial_tx.sv
// Serial transmitter: start, DATA_W bits LSB first, parity, stop; start bit appears the cycle after accept.
// Accepts only in IDLE; define PARITY_TX_ODD_EN for odd parity (default even).
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = DATA_W_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  parity_serial_tx_if.slave bus
);

  localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef PARITY_TX_ODD_EN
  localparam logic PAR_INV = 1'b1;
`else
  localparam logic PAR_INV = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic              accept;
  logic              bit_tick;

  assign accept = (state_q == ST_IDLE) && bus.in_valid;

  parity_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .run_i    (state_q != ST_IDLE),
    .restart_i(accept),
    .tick_o   (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_START;
      ST_START:  if (bit_tick) state_d = ST_DATA;
      ST_DATA:   if (bit_tick && (idx_q == IDX_LAST)) state_d = ST_PARITY;
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
      ST_STOP:   if (bit_tick) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Payload and its parity are frozen at accept so later data_in changes cannot leak into the frame.
  always_comb begin
    data_d = data_q;
    par_d  = par_q;
    idx_d  = idx_q;
    done_d = (state_q == ST_STOP) && bit_tick;
    if (accept) begin
      data_d = bus.data_in;
      par_d  = (^bus.data_in) ^ PAR_INV;
    end
    if ((state_q == ST_DATA) && bit_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      par_q  <= 1'b0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    bus.in_ready = (state_q == ST_IDLE);
    bus.busy     = (state_q != ST_IDLE);
    bus.tx_done  = done_q;
    case (state_q)
      ST_START:  bus.tx = 1'b0;
      ST_DATA:   bus.tx = data_q[idx_q];
      ST_PARITY: bus.tx = par_q;
      default:   bus.tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: CLKS_PER_BIT=4 instance for framing/handshake/reset, CLKS_PER_BIT=1 instance for the short frame.
module tb_parity_serial_tx;

`ifdef PARITY_TX_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  localparam int CPB4 = 4;
  localparam int FRAME4 = 11 * CPB4;

  logic clk;
  logic rst;
  logic rst1;

  int checks;
  int errors;

  parity_serial_tx_if #(.DATA_W(8)) bus4 ();
  parity_serial_tx_if #(.DATA_W(8)) bus1 ();

  parity_serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4)
  );

  parity_serial_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
    .clk(clk),
    .rst(rst1),
    .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       par_even;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller is positioned at a negedge; returns at the negedge of the tx_done cycle.
  task automatic run_frame(input logic [7:0] d, input logic p, input bit hold, input bit glitch);
    logic [10:0] fr;
    int          n;
    fr = {1'b1, p, d, 1'b0};
    bus4.data_in  = d;
    bus4.in_valid = 1'b1;
    n = 0;
    while (!bus4.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    for (int c = 1; c <= FRAME4; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) bus4.in_valid = 1'b0;
      if (glitch && c == 18) begin
        bus4.data_in  = ~d;
        bus4.in_valid = 1'b1;
      end
      if (glitch && c == 19) bus4.in_valid = 1'b0;
      chk("tx_bit", 32'(bus4.tx), 32'(fr[(c - 1) / CPB4]));
      chk("busy_rdy_done_in_frame", 32'({bus4.busy, bus4.in_ready, bus4.tx_done}), 32'b100);
    end
    @(negedge clk);
    chk("done_cycle", 32'({bus4.tx_done, bus4.tx, bus4.in_ready, bus4.busy}), 32'b1110);
  endtask

  initial begin
    logic [10:0] fr1;
    bit          seen_done;

    checks = 0;
    errors = 0;
    rst  = 1'b1;
    rst1 = 1'b1;
    bus4.data_in = '0; bus4.in_valid = 1'b0;
    bus1.data_in = '0; bus1.in_valid = 1'b0;

    vecs[0] = '{d: 8'hA5, par_even: 1'b0};
    vecs[1] = '{d: 8'h01, par_even: 1'b1};
    vecs[2] = '{d: 8'hFF, par_even: 1'b0};
    vecs[3] = '{d: 8'h3C, par_even: 1'b0};
    vecs[4] = '{d: 8'h00, par_even: 1'b0};
    vecs[5] = '{d: 8'h80, par_even: 1'b1};

    @(negedge clk);
    chk("reset4", 32'({bus4.tx, bus4.in_ready, bus4.busy, bus4.tx_done}), 32'b1100);
    chk("reset1", 32'({bus1.tx, bus1.in_ready, bus1.busy, bus1.tx_done}), 32'b1100);
    rst  = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    // Table-driven single frames, tx_done checked for a one-cycle pulse.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].d, vecs[i].par_even ^ ODD, 1'b0, 1'b0);
      @(negedge clk);
      chk("done_one_cycle", 32'({bus4.tx_done, bus4.in_ready, bus4.tx}), 32'b011);
    end

    // Back-to-back: valid held through frame 1, next payload taken in the tx_done cycle.
    run_frame(8'h3C, 1'b0 ^ ODD, 1'b1, 1'b0);
    run_frame(8'hC3, 1'b0 ^ ODD, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_idle_after", 32'({bus4.busy, bus4.tx}), 32'b01);

    // Data change and valid pulse mid-frame must not disturb or queue anything.
    run_frame(8'h5A, 1'b0 ^ ODD, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_second_accept", 32'({bus4.busy, bus4.tx}), 32'b01);
    end

    // Reset during data bit 3 (frame cycles 17..20) aborts immediately.
    bus4.data_in  = 8'hA5;
    bus4.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_abort_busy", 32'({bus4.busy, bus4.tx}), 32'b10);
    rst = 1'b1;
    #1;
    chk("abort_async", 32'({bus4.tx, bus4.busy, bus4.in_ready, bus4.tx_done}), 32'b1010);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus4.tx_done) seen_done = 1'b1;
    end
    chk("no_done_after_abort", 32'(seen_done), 32'd0);
    run_frame(8'h3C, 1'b0 ^ ODD, 1'b0, 1'b0);

    // CLKS_PER_BIT=1: 11-cycle frame, tx_done in cycle 12.
    @(negedge clk);
    fr1 = {1'b1, 1'b0 ^ ODD, 8'hFF, 1'b0};
    bus1.data_in  = 8'hFF;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) bus1.in_valid = 1'b0;
      chk("cpb1_tx_bit", 32'(bus1.tx), 32'(fr1[c - 1]));
      chk("cpb1_busy", 32'({bus1.busy, bus1.tx_done}), 32'b10);
    end
    @(negedge clk);
    chk("cpb1_done", 32'({bus1.tx_done, bus1.tx, bus1.busy}), 32'b110);
    @(negedge clk);
    chk("cpb1_done_clear", 32'(bus1.tx_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
